// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_CSUM,
    ST_RUN,
    ST_ERROR
  } state_t;

  localparam int unsigned HDR_BYTES = 2;
  localparam int unsigned LANES     = 4;
  localparam int unsigned LANE_W    = $clog2(LANES);
  localparam int unsigned WORD_W    = LANES * 8;
  localparam int unsigned N_W       = HDR_BYTES * 8;

  // States in which the loader is consuming the byte stream.
  function automatic logic is_loading(input state_t s);
    return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/program_loader_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; flags the completing byte.
module word_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        data,
  input  logic              accept,
  input  logic              clear,
  output logic [WORD_W-1:0] word_c,
  output logic              word_ready_c
);

  logic [LANE_W-1:0] lane;
  logic [WORD_W-1:0] pack;

  // Shift right so the first byte of a word ends up in bits [7:0].
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane <= '0;
      pack <= '0;
    end else if (accept) begin
      lane <= lane + LANE_W'(1);
      pack <= {data, pack[WORD_W-1:8]};
    end
  end

  assign word_ready_c = accept && (lane == LANE_W'(LANES - 1));
  assign word_c       = {data, pack[WORD_W-1:8]};

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, checksummed byte stream into instruction memory and
// holds the CPU in reset until a load completes with a matching checksum.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic              error_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned CMP_W = N_W + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [N_W-1:0]    n_cnt, n_n, n_new;
  logic [7:0]        csum, csum_n;
  logic [TMO_W-1:0]  tmo, tmo_n;
  logic              rx_ready_n, we_n, cpu_rst_n, done_n, error_n;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]       wdata_n;

  logic              accept;
  logic              loading;
  logic              start_load;
  logic              pack_accept;
  logic [WORD_W-1:0] word;
  logic              word_ready;

  assign accept      = rx_valid_i && rx_ready_o;
  assign loading     = is_loading(state);
  assign pack_accept = accept && (state == ST_DATA);

  word_packer u_packer (
    .clk          (CLK),
    .rst          (RST),
    .data         (rx_data_i),
    .accept       (pack_accept),
    .clear        (start_load),
    .word_c       (word),
    .word_ready_c (word_ready)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_IDLE;
      idx          <= '0;
      n_cnt        <= '0;
      csum         <= '0;
      tmo          <= '0;
      rx_ready_o   <= 1'b0;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      cpu_rst_o    <= 1'b1;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      n_cnt        <= n_n;
      csum         <= csum_n;
      tmo          <= tmo_n;
      rx_ready_o   <= rx_ready_n;
      imem_we_o    <= we_n;
      imem_addr_o  <= addr_n;
      imem_wdata_o <= wdata_n;
      cpu_rst_o    <= cpu_rst_n;
      done_o       <= done_n;
      error_o      <= error_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    n_n        = n_cnt;
    n_new      = {rx_data_i, n_cnt[7:0]};
    csum_n     = csum;
    tmo_n      = tmo;
    we_n       = 1'b0;
    addr_n     = imem_addr_o;
    wdata_n    = imem_wdata_o;
    start_load = 1'b0;

    // Idle-cycle counter; saturates so it never wraps past the limit.
    if (loading) begin
      if (accept)
        tmo_n = '0;
      else if (tmo != TMO_W'(TIMEOUT))
        tmo_n = tmo + TMO_W'(1);
    end

    case (state)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start_i) start_load = 1'b1;
      end
      ST_HDR0: begin
        if (accept) begin
          n_n     = {n_cnt[N_W-1:8], rx_data_i};
          state_n = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (accept) begin
          n_n = n_new;
          if (CMP_W'(n_new) > CMP_W'(DEPTH))
            state_n = ST_ERROR;
          else if (n_new == '0)
            state_n = ST_CSUM;
          else
            state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) csum_n = csum ^ rx_data_i;
        if (word_ready) begin
          we_n    = 1'b1;
          addr_n  = idx[ADDR_W-1:0];
          wdata_n = word;
          idx_n   = idx + IDX_W'(1);
          if (CMP_W'(idx) + CMP_W'(1) == CMP_W'(n_cnt)) state_n = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (accept) state_n = (rx_data_i == csum) ? ST_RUN : ST_ERROR;
      end
      default: state_n = ST_IDLE;
    endcase

    if (loading && !accept && (tmo_n == TMO_W'(TIMEOUT))) begin
      state_n = ST_ERROR;
      we_n    = 1'b0;
    end

    if (start_load) begin
      state_n = ST_HDR0;
      idx_n   = '0;
      csum_n  = '0;
      tmo_n   = '0;
    end

    // Ready is withheld on the write cycle so a write never overlaps an accept.
    rx_ready_n = is_loading(state_n) && !we_n;
    cpu_rst_n  = (state_n != ST_RUN);
    done_n     = (state_n == ST_RUN);
    error_n    = (state_n == ST_ERROR);
  end

endmodule
